control_unit: RTL and testbench

- Instruction fetch/decode/sequence FSM for the 8-bit CPU, directly upstream of registerset.
- Fetches instruction bytes from program memory over a req/valid handshake and decodes them.
- Drives the registerset read/write ports (rd_en1/2, rd_sel1/2, wr_en, wr_sel), the ALU opcode and the write-data source select.
- Holds the PC and the zero flag.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/instr_decoder.sv | 41 ++++
 rtl/control_unit.sv | 176 +++++++++++++++++
 tb/tb_control_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: widths, opcodes, ALU encodings,
// instruction classes and sequencer states.
package cpu_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_SEL_WIDTH  = 2;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_OP_WIDTH   = 4;

  localparam logic [3:0] OPC_NOP = 4'h0;
  localparam logic [3:0] OPC_LDI = 4'h1;
  localparam logic [3:0] OPC_MOV = 4'h2;
  localparam logic [3:0] OPC_ADD = 4'h3;
  localparam logic [3:0] OPC_SUB = 4'h4;
  localparam logic [3:0] OPC_AND = 4'h5;
  localparam logic [3:0] OPC_OR  = 4'h6;
  localparam logic [3:0] OPC_XOR = 4'h7;
  localparam logic [3:0] OPC_JZ  = 4'h8;
  localparam logic [3:0] OPC_JMP = 4'h9;
  localparam logic [3:0] OPC_HLT = 4'hF;

  // ALU operations share the opcode numbering; PASS_B reuses the MOV slot.
  localparam logic [DEF_OP_WIDTH-1:0] ALU_NONE   = 4'h0;
  localparam logic [DEF_OP_WIDTH-1:0] ALU_PASS_B = 4'h2;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_LDI,
    CLS_MOV,
    CLS_ALU,
    CLS_JZ,
    CLS_JMP,
    CLS_HLT
  } instr_class_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_FETCH_OP,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALT
  } state_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction byte decoder: [7:4] opcode, [3:2] rd, [1:0] rs.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [DEF_DATA_WIDTH-1:0] instr,
  output instr_class_e              cls,
  output logic [DEF_SEL_WIDTH-1:0]  rd,
  output logic [DEF_SEL_WIDTH-1:0]  rs,
  output logic [DEF_OP_WIDTH-1:0]   alu_op,
  output logic                      two_byte
);

  logic [3:0] opcode;

  assign opcode   = instr[7:4];
  assign rd       = instr[3:2];
  assign rs       = instr[1:0];
  assign two_byte = (cls == CLS_LDI) || (cls == CLS_JZ) || (cls == CLS_JMP);

  // Map the opcode onto an instruction class and ALU operation; unused opcodes behave as NOP.
  always_comb begin
    cls    = CLS_NOP;
    alu_op = ALU_NONE;
    case (opcode)
      OPC_LDI: cls = CLS_LDI;
      OPC_MOV: begin
        cls    = CLS_MOV;
        alu_op = ALU_PASS_B;
      end
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR: begin
        cls    = CLS_ALU;
        alu_op = opcode;
      end
      OPC_JZ:  cls = CLS_JZ;
      OPC_JMP: cls = CLS_JMP;
      OPC_HLT: cls = CLS_HLT;
      default: cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/sequence FSM for the 8-bit CPU. Owns the PC and zero flag and
// drives the registerset ports, ALU opcode and write-data select.
module control_unit
  import cpu_pkg::*;
#(
  parameter int DataWidth  = DEF_DATA_WIDTH,
  parameter int SEL_WIDTH  = DEF_SEL_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int OP_WIDTH   = DEF_OP_WIDTH
) (
  input  logic                  clk,
  input  logic                  res_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_req,
  input  logic                  imem_valid,
  input  logic [DataWidth-1:0]  imem_data,
  output logic                  rd_en1,
  output logic                  rd_en2,
  output logic [SEL_WIDTH-1:0]  rd_sel1,
  output logic [SEL_WIDTH-1:0]  rd_sel2,
  output logic                  wr_en,
  output logic [SEL_WIDTH-1:0]  wr_sel,
  output logic                  reg_in_sel,
  output logic [DataWidth-1:0]  imm,
  output logic [OP_WIDTH-1:0]   alu_op,
  input  logic                  alu_zero,
  output logic                  halted
);

  state_e                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [DataWidth-1:0]  ir;
  logic                  zflag;
  logic                  fetch_ok;

  logic [DataWidth-1:0]  dec_in;
  instr_class_e          dec_cls;
  logic [SEL_WIDTH-1:0]  dec_rd;
  logic [SEL_WIDTH-1:0]  dec_rs;
  logic [OP_WIDTH-1:0]   dec_alu_op;
  logic                  dec_two_byte;

  // The PC register doubles as the fetch address, so it cannot move while a request is open.
  assign imem_addr = pc;
  assign pc_inc    = pc + ADDR_WIDTH'(1);
  assign fetch_ok  = imem_req & imem_valid;

  // In FETCH the incoming byte is decoded so the DECODE-cycle read enables can be registered;
  // in every later state the latched instruction is decoded.
  assign dec_in = (state == ST_FETCH) ? imem_data : ir;

  instr_decoder u_decoder (
    .instr    (dec_in),
    .cls      (dec_cls),
    .rd       (dec_rd),
    .rs       (dec_rs),
    .alu_op   (dec_alu_op),
    .two_byte (dec_two_byte)
  );

  // Sequencer: every output is registered and computed for the state being entered.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state      <= ST_FETCH;
      pc         <= '0;
      ir         <= '0;
      imm        <= '0;
      zflag      <= 1'b0;
      imem_req   <= 1'b0;
      rd_en1     <= 1'b0;
      rd_en2     <= 1'b0;
      rd_sel1    <= '0;
      rd_sel2    <= '0;
      wr_en      <= 1'b0;
      wr_sel     <= '0;
      reg_in_sel <= 1'b0;
      alu_op     <= '0;
      halted     <= 1'b0;
    end else begin
      imem_req   <= 1'b0;
      rd_en1     <= 1'b0;
      rd_en2     <= 1'b0;
      rd_sel1    <= '0;
      rd_sel2    <= '0;
      wr_en      <= 1'b0;
      wr_sel     <= '0;
      reg_in_sel <= 1'b0;
      alu_op     <= '0;
      halted     <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (fetch_ok) begin
            ir    <= imem_data;
            pc    <= pc_inc;
            state <= ST_DECODE;
            if (dec_cls == CLS_MOV || dec_cls == CLS_ALU) begin
              rd_en1  <= 1'b1;
              rd_sel1 <= dec_rd;
              rd_en2  <= 1'b1;
              rd_sel2 <= dec_rs;
            end
          end else begin
            imem_req <= 1'b1;
          end
        end
        ST_DECODE: begin
          case (dec_cls)
            CLS_MOV, CLS_ALU: begin
              state   <= ST_EXECUTE;
              rd_en1  <= 1'b1;
              rd_sel1 <= dec_rd;
              rd_en2  <= 1'b1;
              rd_sel2 <= dec_rs;
              alu_op  <= dec_alu_op;
            end
            CLS_HLT: begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end
            default: begin
              imem_req <= 1'b1;
              state    <= dec_two_byte ? ST_FETCH_OP : ST_FETCH;
            end
          endcase
        end
        ST_FETCH_OP: begin
          if (fetch_ok) begin
            imm <= imem_data;
            if (dec_cls == CLS_LDI) begin
              pc         <= pc_inc;
              state      <= ST_WRITEBACK;
              wr_en      <= 1'b1;
              wr_sel     <= dec_rd;
              reg_in_sel <= 1'b1;
            end else begin
              imem_req <= 1'b1;
              state    <= ST_FETCH;
              if (dec_cls == CLS_JMP || (dec_cls == CLS_JZ && zflag)) begin
                pc <= imem_data;
              end else begin
                pc <= pc_inc;
              end
            end
          end else begin
            imem_req <= 1'b1;
          end
        end
        ST_EXECUTE: begin
          if (dec_cls == CLS_ALU) begin
            zflag <= alu_zero;
          end
          state   <= ST_WRITEBACK;
          rd_en1  <= 1'b1;
          rd_sel1 <= dec_rd;
          rd_en2  <= 1'b1;
          rd_sel2 <= dec_rs;
          alu_op  <= dec_alu_op;
          wr_en   <= 1'b1;
          wr_sel  <= dec_rd;
        end
        ST_WRITEBACK: begin
          imem_req <= 1'b1;
          state    <= ST_FETCH;
        end
        ST_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit: each step applies inputs,
// clocks once and compares every output against hand-computed values.
module tb_control_unit;

  typedef struct packed {
    logic       req;
    logic [7:0] addr;
    logic       en1;
    logic       en2;
    logic [1:0] s1;
    logic [1:0] s2;
    logic       we;
    logic [1:0] ws;
    logic       ris;
    logic [7:0] imm;
    logic [3:0] op;
    logic       halt;
  } outs_t;

  typedef struct {
    logic       rst_n;
    logic       v;
    logic [7:0] d;
    logic       z;
    outs_t      exp;
  } vec_t;

  logic       clk;
  logic       res_n;
  logic [7:0] imem_addr;
  logic       imem_req;
  logic       imem_valid;
  logic [7:0] imem_data;
  logic       rd_en1;
  logic       rd_en2;
  logic [1:0] rd_sel1;
  logic [1:0] rd_sel2;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic       reg_in_sel;
  logic [7:0] imm;
  logic [3:0] alu_op;
  logic       alu_zero;
  logic       halted;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  control_unit dut (
    .clk        (clk),
    .res_n      (res_n),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .rd_en1     (rd_en1),
    .rd_en2     (rd_en2),
    .rd_sel1    (rd_sel1),
    .rd_sel2    (rd_sel2),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .reg_in_sel (reg_in_sel),
    .imm        (imm),
    .alu_op     (alu_op),
    .alu_zero   (alu_zero),
    .halted     (halted)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic outs_t mk(logic req, logic [7:0] addr, logic en, logic [1:0] s1, logic [1:0] s2,
                               logic we, logic [1:0] ws, logic ris, logic [7:0] imm_v, logic [3:0] op,
                               logic halt);
    outs_t o;
    o.req  = req;
    o.addr = addr;
    o.en1  = en;
    o.en2  = en;
    o.s1   = s1;
    o.s2   = s2;
    o.we   = we;
    o.ws   = ws;
    o.ris  = ris;
    o.imm  = imm_v;
    o.op   = op;
    o.halt = halt;
    return o;
  endfunction

  function automatic outs_t o_idle(logic [7:0] addr, logic [7:0] imm_v);
    return mk(1'b0, addr, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, imm_v, 4'h0, 1'b0);
  endfunction

  function automatic outs_t o_fetch(logic [7:0] addr, logic [7:0] imm_v);
    return mk(1'b1, addr, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, imm_v, 4'h0, 1'b0);
  endfunction

  function automatic outs_t o_dec(logic [7:0] addr, logic [1:0] s1, logic [1:0] s2, logic [7:0] imm_v);
    return mk(1'b0, addr, 1'b1, s1, s2, 1'b0, 2'd0, 1'b0, imm_v, 4'h0, 1'b0);
  endfunction

  function automatic outs_t o_exec(logic [7:0] addr, logic [1:0] s1, logic [1:0] s2, logic [7:0] imm_v,
                                   logic [3:0] op);
    return mk(1'b0, addr, 1'b1, s1, s2, 1'b0, 2'd0, 1'b0, imm_v, op, 1'b0);
  endfunction

  function automatic outs_t o_wb(logic [7:0] addr, logic [1:0] s1, logic [1:0] s2, logic [7:0] imm_v,
                                 logic [3:0] op);
    return mk(1'b0, addr, 1'b1, s1, s2, 1'b1, s1, 1'b0, imm_v, op, 1'b0);
  endfunction

  function automatic outs_t o_wbi(logic [7:0] addr, logic [1:0] ws, logic [7:0] imm_v);
    return mk(1'b0, addr, 1'b0, 2'd0, 2'd0, 1'b1, ws, 1'b1, imm_v, 4'h0, 1'b0);
  endfunction

  function automatic outs_t o_halt(logic [7:0] addr, logic [7:0] imm_v);
    return mk(1'b0, addr, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, imm_v, 4'h0, 1'b1);
  endfunction

  function automatic string fmt(outs_t o);
    return $sformatf("req=%b addr=%h en=%b%b sel=%0d/%0d we=%b ws=%0d ris=%b imm=%h op=%h halt=%b",
                     o.req, o.addr, o.en1, o.en2, o.s1, o.s2, o.we, o.ws, o.ris, o.imm, o.op, o.halt);
  endfunction

  task automatic add_vec(input logic rst_n, input logic v, input logic [7:0] d, input logic z,
                         input outs_t e);
    vec_t t;
    t.rst_n = rst_n;
    t.v     = v;
    t.d     = d;
    t.z     = z;
    t.exp   = e;
    vecs.push_back(t);
  endtask

  task automatic apply_stimulus(input logic rst_n, input logic v, input logic [7:0] d, input logic z);
    @(negedge clk);
    res_n      = rst_n;
    imem_valid = v;
    imem_data  = d;
    alu_zero   = z;
  endtask

  task automatic check_output(input string name, input outs_t e);
    outs_t act;
    act = {imem_req, imem_addr, rd_en1, rd_en2, rd_sel1, rd_sel2, wr_en, wr_sel, reg_in_sel,
           imm, alu_op, halted};
    checks++;
    if (act !== e) begin
      errors++;
      $display("[TB] FAIL %s: got %s, want %s", name, fmt(act), fmt(e));
    end
  endtask

  task automatic run_step(input string name, input logic rst_n, input logic v, input logic [7:0] d,
                          input logic z, input outs_t e);
    apply_stimulus(rst_n, v, d, z);
    @(posedge clk);
    #1;
    check_output(name, e);
  endtask

  // Main test: program table first, then the multi-cycle corner cases.
  initial begin
    res_n      = 1'b0;
    imem_valid = 1'b1;
    imem_data  = 8'h1C;
    alu_zero   = 1'b0;

    // Reset held with valid asserted, then release (valid ignored while req=0).
    add_vec(0, 1, 8'h1C, 0, o_idle(8'h00, 8'h00));
    add_vec(0, 1, 8'h1C, 0, o_idle(8'h00, 8'h00));
    add_vec(0, 1, 8'h1C, 0, o_idle(8'h00, 8'h00));
    add_vec(1, 1, 8'h1C, 0, o_fetch(8'h00, 8'h00));
    // LDI R3,#255
    add_vec(1, 1, 8'h1C, 0, o_idle(8'h01, 8'h00));
    add_vec(1, 1, 8'hEE, 0, o_fetch(8'h01, 8'h00));
    add_vec(1, 1, 8'hFF, 0, o_wbi(8'h02, 2'd3, 8'hFF));
    add_vec(1, 1, 8'hEE, 0, o_fetch(8'h02, 8'hFF));
    // LDI R0,#128
    add_vec(1, 1, 8'h10, 0, o_idle(8'h03, 8'hFF));
    add_vec(1, 1, 8'hEE, 0, o_fetch(8'h03, 8'hFF));
    add_vec(1, 1, 8'h80, 0, o_wbi(8'h04, 2'd0, 8'h80));
    add_vec(1, 1, 8'hEE, 0, o_fetch(8'h04, 8'h80));
    // ADD R0,R3 (0x33), alu_zero=0
    add_vec(1, 1, 8'h33, 0, o_dec(8'h05, 2'd0, 2'd3, 8'h80));
    add_vec(1, 1, 8'hEE, 0, o_exec(8'h05, 2'd0, 2'd3, 8'h80, 4'h3));
    add_vec(1, 1, 8'hEE, 0, o_wb(8'h05, 2'd0, 2'd3, 8'h80, 4'h3));
    add_vec(1, 1, 8'hEE, 0, o_fetch(8'h05, 8'h80));
    // SUB R1,R1 with alu_zero=1, then JZ 0x10 taken
    add_vec(1, 1, 8'h45, 0, o_dec(8'h06, 2'd1, 2'd1, 8'h80));
    add_vec(1, 1, 8'hEE, 0, o_exec(8'h06, 2'd1, 2'd1, 8'h80, 4'h4));
    add_vec(1, 1, 8'hEE, 1, o_wb(8'h06, 2'd1, 2'd1, 8'h80, 4'h4));
    add_vec(1, 1, 8'hEE, 0, o_fetch(8'h06, 8'h80));
    add_vec(1, 1, 8'h80, 0, o_idle(8'h07, 8'h80));
    add_vec(1, 1, 8'hEE, 0, o_fetch(8'h07, 8'h80));
    add_vec(1, 1, 8'h10, 0, o_fetch(8'h10, 8'h10));
    // SUB R1,R1 with alu_zero=0, then JZ 0x40 falls through to 0x13
    add_vec(1, 1, 8'h45, 0, o_dec(8'h11, 2'd1, 2'd1, 8'h10));
    add_vec(1, 1, 8'hEE, 0, o_exec(8'h11, 2'd1, 2'd1, 8'h10, 4'h4));
    add_vec(1, 1, 8'hEE, 0, o_wb(8'h11, 2'd1, 2'd1, 8'h10, 4'h4));
    add_vec(1, 1, 8'hEE, 1, o_fetch(8'h11, 8'h10));
    add_vec(1, 1, 8'h80, 1, o_idle(8'h12, 8'h10));
    add_vec(1, 1, 8'hEE, 1, o_fetch(8'h12, 8'h10));
    add_vec(1, 1, 8'h40, 1, o_fetch(8'h13, 8'h40));
    // MOV R2,R0 with alu_zero=1 must not set zflag: following JZ falls through
    add_vec(1, 1, 8'h28, 1, o_dec(8'h14, 2'd2, 2'd0, 8'h40));
    add_vec(1, 1, 8'hEE, 1, o_exec(8'h14, 2'd2, 2'd0, 8'h40, 4'h2));
    add_vec(1, 1, 8'hEE, 1, o_wb(8'h14, 2'd2, 2'd0, 8'h40, 4'h2));
    add_vec(1, 1, 8'hEE, 1, o_fetch(8'h14, 8'h40));
    add_vec(1, 1, 8'h80, 1, o_idle(8'h15, 8'h40));
    add_vec(1, 1, 8'hEE, 1, o_fetch(8'h15, 8'h40));
    add_vec(1, 1, 8'h30, 1, o_fetch(8'h16, 8'h30));
    // JMP 0x50, NOP, opcode A treated as NOP
    add_vec(1, 1, 8'h90, 0, o_idle(8'h17, 8'h30));
    add_vec(1, 1, 8'hEE, 0, o_fetch(8'h17, 8'h30));
    add_vec(1, 1, 8'h50, 0, o_fetch(8'h50, 8'h50));
    add_vec(1, 1, 8'h00, 0, o_idle(8'h51, 8'h50));
    add_vec(1, 1, 8'hEE, 0, o_fetch(8'h51, 8'h50));
    add_vec(1, 1, 8'hA5, 0, o_idle(8'h52, 8'h50));
    add_vec(1, 1, 8'hEE, 0, o_fetch(8'h52, 8'h50));

    for (int i = 0; i < vecs.size(); i++) begin
      run_step($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].v, vecs[i].d, vecs[i].z, vecs[i].exp);
    end

    // Wait states in FETCH and FETCH_OP: request and address held, nothing enabled.
    for (int i = 0; i < 3; i++) run_step($sformatf("wait_fetch%0d", i), 1, 0, 8'h14, 0, o_fetch(8'h52, 8'h50));
    run_step("wait_dec", 1, 1, 8'h14, 0, o_idle(8'h53, 8'h50));
    run_step("wait_fop_enter", 1, 0, 8'hEE, 0, o_fetch(8'h53, 8'h50));
    for (int i = 0; i < 3; i++) run_step($sformatf("wait_fop%0d", i), 1, 0, 8'h5A, 0, o_fetch(8'h53, 8'h50));
    run_step("wait_wb", 1, 1, 8'h5A, 0, o_wbi(8'h54, 2'd1, 8'h5A));
    run_step("wait_done", 1, 1, 8'hEE, 0, o_fetch(8'h54, 8'h5A));

    // JMP 0xFE, then LDI R2 straddling the 0xFF->0x00 wrap.
    run_step("wrap_jmp_dec", 1, 1, 8'h90, 0, o_idle(8'h55, 8'h5A));
    run_step("wrap_jmp_fop", 1, 1, 8'hEE, 0, o_fetch(8'h55, 8'h5A));
    run_step("wrap_jmp_tgt", 1, 1, 8'hFE, 0, o_fetch(8'hFE, 8'hFE));
    run_step("wrap_ldi_dec", 1, 1, 8'h18, 0, o_idle(8'hFF, 8'hFE));
    run_step("wrap_ldi_fop", 1, 1, 8'hEE, 0, o_fetch(8'hFF, 8'hFE));
    run_step("wrap_ldi_wb", 1, 1, 8'h77, 0, o_wbi(8'h00, 2'd2, 8'h77));
    run_step("wrap_fetch", 1, 1, 8'hEE, 0, o_fetch(8'h00, 8'h77));

    // JMP 0xFF, HLT there: PC wraps to 0 and the core stays halted.
    run_step("halt_jmp_dec", 1, 1, 8'h90, 0, o_idle(8'h01, 8'h77));
    run_step("halt_jmp_fop", 1, 1, 8'hEE, 0, o_fetch(8'h01, 8'h77));
    run_step("halt_jmp_tgt", 1, 1, 8'hFF, 0, o_fetch(8'hFF, 8'hFF));
    run_step("halt_dec", 1, 1, 8'hF0, 0, o_idle(8'h00, 8'hFF));
    for (int i = 0; i < 20; i++) begin
      logic [7:0] junk;
      junk = 8'(i * 37);
      run_step($sformatf("halt%0d", i), 1, i[0], junk, i[1], o_halt(8'h00, 8'hFF));
    end

    // Reset out of HALT, then reset arriving on the edge that would enter WRITEBACK.
    run_step("rst_halt", 0, 1, 8'hEE, 0, o_idle(8'h00, 8'h00));
    run_step("rst_rel1", 1, 1, 8'h1C, 0, o_fetch(8'h00, 8'h00));
    run_step("rst1_dec", 1, 1, 8'h1C, 0, o_idle(8'h01, 8'h00));
    run_step("rst1_fop", 1, 1, 8'hEE, 0, o_fetch(8'h01, 8'h00));
    run_step("rst1_hit", 0, 1, 8'h42, 0, o_idle(8'h00, 8'h00));
    run_step("rst_rel2", 1, 1, 8'h1C, 0, o_fetch(8'h00, 8'h00));

    // Reset during the WRITEBACK cycle itself drops wr_en and the PC.
    run_step("rst2_dec", 1, 1, 8'h1C, 0, o_idle(8'h01, 8'h00));
    run_step("rst2_fop", 1, 1, 8'hEE, 0, o_fetch(8'h01, 8'h00));
    run_step("rst2_wb", 1, 1, 8'h42, 0, o_wbi(8'h02, 2'd3, 8'h42));
    run_step("rst2_hit", 0, 1, 8'h1C, 0, o_idle(8'h00, 8'h00));
    run_step("rst_rel3", 1, 1, 8'h1C, 0, o_fetch(8'h00, 8'h00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
